// File: rtl/boundary_mixer_array.sv
// Time-multiplexed boundary oscillator generator: one boundary per adjacent oscillator pair,
// geometric-mean amplitude along the averaged unit phase vector, committed atomically.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for clk_en strobe; snapshot inputs on strobe
// S_AMP    | amplitude estimate of pair k, or zero-fill slot k if disabled
// S_SQRT   | bit-serial sqrt of a_lo*a_hi -> geometric-mean amplitude G
// S_DIV    | four serial divides giving unit vectors u_lo, u_hi
// S_MIX    | average, scale by G*mix, write shadow slot k, advance k
// S_COMMIT | copy shadow slots to outputs, pulse valid
module boundary_mixer_array #(
   parameter int WIDTH   = 18,
   parameter int FRAC    = 14,
   parameter int N_OSC   = 4,
   parameter int MIN_AMP = 164
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clk_en,
   input  logic [N_OSC*WIDTH-1:0]         osc_x_flat,
   input  logic [N_OSC*WIDTH-1:0]         osc_y_flat,
   input  logic [(N_OSC-1)*WIDTH-1:0]     mix_flat,
   input  logic [N_OSC-2:0]               chan_en,
   output logic [(N_OSC-1)*WIDTH-1:0]     boundary_x_flat,
   output logic [(N_OSC-1)*WIDTH-1:0]     boundary_y_flat,
   output logic [(N_OSC-1)*WIDTH-1:0]     boundary_amp_flat,
   output logic                           valid,
   output logic                           busy,
   output logic                           overrun
);

   localparam int NB = N_OSC - 1;
   localparam int KW = $clog2(N_OSC);
   localparam int DW = WIDTH + FRAC;
   localparam int CW = $clog2(DW);
   localparam int MW = 2*WIDTH + 2;
   localparam int XW = MW + WIDTH + 1;
   localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_AMP    = 3'd1;
   localparam logic [2:0] S_SQRT   = 3'd2;
   localparam logic [2:0] S_DIV    = 3'd3;
   localparam logic [2:0] S_MIX    = 3'd4;
   localparam logic [2:0] S_COMMIT = 3'd5;

   function automatic logic [WIDTH-1:0] mag_of(input logic signed [WIDTH-1:0] v);
      mag_of = v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
   endfunction

   // max + 0.4*min; never exceeds WIDTH unsigned bits for WIDTH-bit signed inputs
   function automatic logic [WIDTH-1:0] amp_est(input logic signed [WIDTH-1:0] x,
                                                input logic signed [WIDTH-1:0] y);
      logic [WIDTH-1:0]  ax, ay, hi, lo;
      logic [WIDTH+13:0] lo_k;
      ax = mag_of(x);
      ay = mag_of(y);
      hi = (ax > ay) ? ax : ay;
      lo = (ax > ay) ? ay : ax;
      lo_k = (WIDTH+14)'(lo) * (WIDTH+14)'(14'd6554);
      amp_est = hi + WIDTH'(lo_k >> FRAC);
   endfunction

   function automatic logic signed [WIDTH-1:0] sat_x(input logic signed [XW-1:0] v);
      logic signed [XW-1:0] hi_lim, lo_lim;
      hi_lim = XW'(SMAX);
      lo_lim = -hi_lim;
      if (v > hi_lim)      sat_x = SMAX;
      else if (v < lo_lim) sat_x = -SMAX;
      else                 sat_x = v[WIDTH-1:0];
   endfunction

   logic [2:0]               state;
   logic [KW-1:0]            k;
   logic signed [WIDTH-1:0]  snap_x   [N_OSC];
   logic signed [WIDTH-1:0]  snap_y   [N_OSC];
   logic signed [WIDTH-1:0]  snap_mix [NB];
   logic [NB-1:0]            snap_en;
   logic [WIDTH-1:0]         a_lo, a_hi, g;
   logic [2*WIDTH-1:0]       sq_p;
   logic [WIDTH+1:0]         sq_rem;
   logic [WIDTH-1:0]         sq_root;
   logic [CW-1:0]            cnt;
   logic [1:0]               div_idx;
   logic [DW-1:0]            dv_dvd;
   logic [WIDTH-1:0]         dv_rem;
   logic                     dv_neg;
   logic signed [WIDTH-1:0]  u [4];
   logic signed [WIDTH-1:0]  sh_x   [NB];
   logic signed [WIDTH-1:0]  sh_y   [NB];
   logic signed [WIDTH-1:0]  sh_amp [NB];

   logic signed [WIDTH-1:0]  x_lo, y_lo, x_hi, y_hi, mix_k;
   logic                     en_k, last_k;
   logic [WIDTH-1:0]         amp_lo, amp_hi;
   logic [WIDTH+3:0]         sq_cat, sq_trial;
   logic                     sq_ge;
   logic [WIDTH+1:0]         sq_rem_n;
   logic [WIDTH-1:0]         sq_root_n;
   logic [1:0]               ld_idx;
   logic signed [WIDTH-1:0]  dv_v;
   logic [WIDTH-1:0]         dv_mag, dv_a, dv_div, dv_rem_n;
   logic [WIDTH:0]           dv_cat;
   logic                     dv_ge;
   logic [DW-1:0]            dv_q;
   logic signed [WIDTH-1:0]  u_mag, u_res;
   logic signed [MW-1:0]     g_s, mix_s, m_prod, m_val;
   logic signed [WIDTH:0]    s_x, s_y;
   logic signed [XW-1:0]     bx_full, by_full;
   logic signed [WIDTH-1:0]  bx_sat, by_sat, bamp_sat;
   logic [WIDTH-1:0]         bamp_raw;

   always_comb begin
      x_lo  = '0;
      y_lo  = '0;
      x_hi  = '0;
      y_hi  = '0;
      mix_k = '0;
      en_k  = 1'b0;
      for (int i = 0; i < NB; i++) begin
         if (k == KW'(i)) begin
            x_lo  = snap_x[i];
            y_lo  = snap_y[i];
            x_hi  = snap_x[i+1];
            y_hi  = snap_y[i+1];
            mix_k = snap_mix[i];
            en_k  = snap_en[i];
         end
      end
      last_k = (k == KW'(NB-1));
      amp_lo = amp_est(x_lo, y_lo);
      amp_hi = amp_est(x_hi, y_hi);

      // restoring sqrt: two radicand bits per cycle, one root bit out
      sq_cat    = {sq_rem, sq_p[2*WIDTH-1 -: 2]};
      sq_trial  = {2'b00, sq_root, 2'b01};
      sq_ge     = (sq_cat >= sq_trial);
      sq_rem_n  = sq_ge ? (WIDTH+2)'(sq_cat - sq_trial) : (WIDTH+2)'(sq_cat);
      sq_root_n = {sq_root[WIDTH-2:0], sq_ge};

      ld_idx = (state == S_SQRT) ? 2'd0 : div_idx + 2'd1;
      case (ld_idx)
         2'd0:    dv_v = x_lo;
         2'd1:    dv_v = y_lo;
         2'd2:    dv_v = x_hi;
         default: dv_v = y_hi;
      endcase
      dv_mag   = mag_of(dv_v);
      dv_a     = div_idx[1] ? a_hi : a_lo;
      dv_div   = (dv_a < WIDTH'(MIN_AMP)) ? WIDTH'(MIN_AMP) : dv_a;
      dv_cat   = {dv_rem, dv_dvd[DW-1]};
      dv_ge    = (dv_cat >= {1'b0, dv_div});
      dv_rem_n = dv_ge ? WIDTH'(dv_cat - {1'b0, dv_div}) : dv_cat[WIDTH-1:0];
      dv_q     = {dv_dvd[DW-2:0], dv_ge};
      u_mag    = (dv_q > DW'(SMAX)) ? SMAX : signed'(dv_q[WIDTH-1:0]);
      u_res    = dv_neg ? -u_mag : u_mag;

      g_s      = signed'(MW'(g));
      mix_s    = MW'(mix_k);
      m_prod   = g_s * mix_s;
      m_val    = m_prod >>> FRAC;
      s_x      = ((WIDTH+1)'(u[0]) + (WIDTH+1)'(u[2])) >>> 1;
      s_y      = ((WIDTH+1)'(u[1]) + (WIDTH+1)'(u[3])) >>> 1;
      bx_full  = (XW'(m_val) * XW'(s_x)) >>> FRAC;
      by_full  = (XW'(m_val) * XW'(s_y)) >>> FRAC;
      bx_sat   = sat_x(bx_full);
      by_sat   = sat_x(by_full);
      bamp_raw = amp_est(bx_sat, by_sat);
      bamp_sat = (bamp_raw > WIDTH'(SMAX)) ? SMAX : signed'(bamp_raw);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= S_IDLE;
         k                 <= '0;
         snap_en           <= '0;
         a_lo              <= '0;
         a_hi              <= '0;
         g                 <= '0;
         sq_p              <= '0;
         sq_rem            <= '0;
         sq_root           <= '0;
         cnt               <= '0;
         div_idx           <= '0;
         dv_dvd            <= '0;
         dv_rem            <= '0;
         dv_neg            <= 1'b0;
         valid             <= 1'b0;
         busy              <= 1'b0;
         overrun           <= 1'b0;
         boundary_x_flat   <= '0;
         boundary_y_flat   <= '0;
         boundary_amp_flat <= '0;
         for (int i = 0; i < N_OSC; i++) begin
            snap_x[i] <= '0;
            snap_y[i] <= '0;
         end
         for (int i = 0; i < NB; i++) begin
            snap_mix[i] <= '0;
            sh_x[i]     <= '0;
            sh_y[i]     <= '0;
            sh_amp[i]   <= '0;
         end
         for (int i = 0; i < 4; i++) u[i] <= '0;
      end else begin
         valid <= 1'b0;
         if (clk_en && busy) overrun <= 1'b1;
         case (state)
            S_IDLE: begin
               if (clk_en) begin
                  for (int i = 0; i < N_OSC; i++) begin
                     snap_x[i] <= osc_x_flat[i*WIDTH +: WIDTH];
                     snap_y[i] <= osc_y_flat[i*WIDTH +: WIDTH];
                  end
                  for (int i = 0; i < NB; i++) snap_mix[i] <= mix_flat[i*WIDTH +: WIDTH];
                  snap_en <= chan_en;
                  busy    <= 1'b1;
                  k       <= '0;
                  state   <= S_AMP;
               end
            end
            S_AMP: begin
               if (!en_k) begin
                  for (int i = 0; i < NB; i++) begin
                     if (k == KW'(i)) begin
                        sh_x[i]   <= '0;
                        sh_y[i]   <= '0;
                        sh_amp[i] <= '0;
                     end
                  end
                  if (last_k) state <= S_COMMIT;
                  else begin
                     k     <= k + KW'(1);
                     state <= S_AMP;
                  end
               end else begin
                  a_lo    <= amp_lo;
                  a_hi    <= amp_hi;
                  sq_p    <= (2*WIDTH)'(amp_lo) * (2*WIDTH)'(amp_hi);
                  sq_rem  <= '0;
                  sq_root <= '0;
                  cnt     <= '0;
                  state   <= S_SQRT;
               end
            end
            S_SQRT: begin
               sq_p    <= sq_p << 2;
               sq_rem  <= sq_rem_n;
               sq_root <= sq_root_n;
               cnt     <= cnt + CW'(1);
               if (cnt == CW'(WIDTH-1)) begin
                  g       <= sq_root_n;
                  div_idx <= 2'd0;
                  dv_neg  <= dv_v[WIDTH-1];
                  dv_dvd  <= {dv_mag, {FRAC{1'b0}}};
                  dv_rem  <= '0;
                  cnt     <= '0;
                  state   <= S_DIV;
               end
            end
            S_DIV: begin
               dv_rem <= dv_rem_n;
               dv_dvd <= dv_q;
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(DW-1)) begin
                  u[div_idx] <= u_res;
                  cnt        <= '0;
                  if (div_idx == 2'd3) state <= S_MIX;
                  else begin
                     div_idx <= ld_idx;
                     dv_neg  <= dv_v[WIDTH-1];
                     dv_dvd  <= {dv_mag, {FRAC{1'b0}}};
                     dv_rem  <= '0;
                  end
               end
            end
            S_MIX: begin
               for (int i = 0; i < NB; i++) begin
                  if (k == KW'(i)) begin
                     sh_x[i]   <= bx_sat;
                     sh_y[i]   <= by_sat;
                     sh_amp[i] <= bamp_sat;
                  end
               end
               if (last_k) state <= S_COMMIT;
               else begin
                  k     <= k + KW'(1);
                  state <= S_AMP;
               end
            end
            S_COMMIT: begin
               for (int i = 0; i < NB; i++) begin
                  boundary_x_flat[i*WIDTH +: WIDTH]   <= sh_x[i];
                  boundary_y_flat[i*WIDTH +: WIDTH]   <= sh_y[i];
                  boundary_amp_flat[i*WIDTH +: WIDTH] <= sh_amp[i];
               end
               valid <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_boundary_mixer_array.sv
// Directed bench for boundary_mixer_array: a two-oscillator instance for the per-pair
// arithmetic and a four-oscillator instance for multi-channel sequencing.
module tb_boundary_mixer_array;
   localparam int W = 18;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   logic           clk_en2 = 1'b0;
   logic [2*W-1:0] x2_flat = '0, y2_flat = '0;
   logic [W-1:0]   mix2_flat = '0;
   logic [0:0]     en2 = '0;
   logic [W-1:0]   bx2_flat, by2_flat, ba2_flat;
   logic           valid2, busy2, overrun2;
   logic signed [W-1:0] bx2, by2, ba2;
   assign bx2 = bx2_flat;
   assign by2 = by2_flat;
   assign ba2 = ba2_flat;

   logic           clk_en4 = 1'b0;
   logic [4*W-1:0] x4_flat = '0, y4_flat = '0;
   logic [3*W-1:0] mix4_flat = '0;
   logic [2:0]     en4 = '0;
   logic [3*W-1:0] bx4_flat, by4_flat, ba4_flat;
   logic           valid4, busy4, overrun4;

   boundary_mixer_array #(.N_OSC(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en2),
      .osc_x_flat(x2_flat), .osc_y_flat(y2_flat), .mix_flat(mix2_flat), .chan_en(en2),
      .boundary_x_flat(bx2_flat), .boundary_y_flat(by2_flat), .boundary_amp_flat(ba2_flat),
      .valid(valid2), .busy(busy2), .overrun(overrun2)
   );

   boundary_mixer_array #(.N_OSC(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en4),
      .osc_x_flat(x4_flat), .osc_y_flat(y4_flat), .mix_flat(mix4_flat), .chan_en(en4),
      .boundary_x_flat(bx4_flat), .boundary_y_flat(by4_flat), .boundary_amp_flat(ba4_flat),
      .valid(valid4), .busy(busy4), .overrun(overrun4)
   );

   // Runs one frame on the 2-osc instance; lat counts edges from the capture edge (=1)
   // to the edge after which valid is seen. poke>0 re-strobes at that count.
   task automatic frame2(input logic signed [W-1:0] x0, y0, x1, y1, mix,
                         input int poke, output int lat);
      @(negedge clk);
      x2_flat = {x1, x0};
      y2_flat = {y1, y0};
      mix2_flat = mix;
      en2 = 1'b1;
      clk_en2 = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      x2_flat = '1;
      y2_flat = {W'(5), W'(-7)};
      mix2_flat = '1;
      en2 = 1'b0;
      while (lat < 400) begin
         clk_en2 = (poke != 0 && lat == poke);
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (valid2) break;
      end
      clk_en2 = 1'b0;
   endtask

   task automatic frame4(input logic [4*W-1:0] xs, ys, input logic [3*W-1:0] mixes,
                         input logic [2:0] en, output int lat, output int hold_bad);
      logic [3*W-1:0] px, py, pa;
      hold_bad = 0;
      @(negedge clk);
      px = bx4_flat;
      py = by4_flat;
      pa = ba4_flat;
      x4_flat = xs;
      y4_flat = ys;
      mix4_flat = mixes;
      en4 = en;
      clk_en4 = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      clk_en4 = 1'b0;
      x4_flat = '0;
      mix4_flat = '1;
      en4 = 3'b111;
      while (lat < 700) begin
         if (bx4_flat !== px || by4_flat !== py || ba4_flat !== pa) hold_bad++;
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (valid4) break;
      end
   endtask

   task automatic test_reset();
      #12;
      tests_run++;
      if ({bx2_flat, by2_flat, ba2_flat} !== '0) begin
         tests_failed++;
         $display("FAIL reset_out2: got %h expected 0", {bx2_flat, by2_flat, ba2_flat});
      end
      tests_run++;
      if ({bx4_flat, by4_flat, ba4_flat} !== '0) begin
         tests_failed++;
         $display("FAIL reset_out4: got %h expected 0", {bx4_flat, by4_flat, ba4_flat});
      end
      tests_run++;
      if ({valid2, busy2, overrun2, valid4, busy4, overrun4} !== 6'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b expected 000000",
                  {valid2, busy2, overrun2, valid4, busy4, overrun4});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check2(input string name, input int lat, input int exp_lat,
                         input int ex, input int ey, input int ea);
      tests_run++;
      if (lat !== exp_lat) begin
         tests_failed++;
         $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
      end
      tests_run++;
      if (bx2 !== ex || by2 !== ey || ba2 !== ea) begin
         tests_failed++;
         $display("FAIL %s_value: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                  name, bx2, by2, ba2, ex, ey, ea);
      end
   endtask

   task automatic test_aligned();
      int lat;
      frame2(18'sd8192, 18'sd0, 18'sd8192, 18'sd0, 18'sd16384, 0, lat);
      check2("aligned", lat, 150, 8192, 0, 8192);
      tests_run++;
      if (busy2 !== 1'b0) begin
         tests_failed++;
         $display("FAIL aligned_busy_at_valid: got %b expected 0", busy2);
      end
      @(negedge clk);
      tests_run++;
      if (valid2 !== 1'b0) begin
         tests_failed++;
         $display("FAIL aligned_valid_pulse: got %b expected 0", valid2);
      end
   endtask

   task automatic test_quadrature();
      int lat;
      frame2(18'sd16384, 18'sd0, 18'sd0, 18'sd16384, 18'sd16384, 0, lat);
      check2("quadrature", lat, 150, 8192, 8192, 11469);
   endtask

   task automatic test_antiphase_zero();
      int lat;
      frame2(18'sd8192, 18'sd0, -18'sd8192, 18'sd0, 18'sd16384, 0, lat);
      check2("antiphase", lat, 150, 0, 0, 0);
      frame2(18'sd16384, 18'sd0, 18'sd0, 18'sd16384, 18'sd16384, 0, lat);
      frame2(18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd16384, 0, lat);
      check2("zero_input", lat, 150, 0, 0, 0);
   endtask

   task automatic test_rounding();
      int lat;
      // G=floor(sqrt(2^27))=11585; m=floor(-11585*8193/2^14)=-5794
      frame2(18'sd16384, 18'sd0, 18'sd8192, 18'sd0, -18'sd8193, 0, lat);
      check2("sqrt_floor_neg_mix", lat, 150, -5794, 0, 5794);
      // a=11200; u=(14628,-4388) truncated; by floors to -3000
      frame2(18'sd10000, -18'sd3000, 18'sd10000, -18'sd3000, 18'sd16384, 0, lat);
      check2("div_truncation", lat, 150, 9999, -3000, 11199);
   endtask

   task automatic test_multi_channel();
      int lat, hold_bad;
      int ex[3], ea[3];
      frame4({4{18'd8192}}, '0, {3{18'd8192}}, 3'b101, lat, hold_bad);
      ex = '{4096, 0, 4096};
      ea = '{4096, 0, 4096};
      tests_run++;
      if (lat !== 299) begin
         tests_failed++;
         $display("FAIL multi_latency: got %0d expected 299", lat);
      end
      tests_run++;
      if (hold_bad !== 0) begin
         tests_failed++;
         $display("FAIL multi_hold: got %0d early changes expected 0", hold_bad);
      end
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (signed'(bx4_flat[i*W +: W]) !== ex[i] || signed'(by4_flat[i*W +: W]) !== 0 ||
             signed'(ba4_flat[i*W +: W]) !== ea[i]) begin
            tests_failed++;
            $display("FAIL multi_slot%0d: got (%0d,%0d,%0d) expected (%0d,0,%0d)", i,
                     signed'(bx4_flat[i*W +: W]), signed'(by4_flat[i*W +: W]),
                     signed'(ba4_flat[i*W +: W]), ex[i], ea[i]);
         end
      end
      frame4({4{18'd8192}}, '0, {18'd0, 18'd16384, 18'd0}, 3'b010, lat, hold_bad);
      ex = '{0, 8192, 0};
      ea = '{0, 8192, 0};
      tests_run++;
      if (lat !== 152) begin
         tests_failed++;
         $display("FAIL multi2_latency: got %0d expected 152", lat);
      end
      tests_run++;
      if (hold_bad !== 0) begin
         tests_failed++;
         $display("FAIL multi2_hold: got %0d early changes expected 0", hold_bad);
      end
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (signed'(bx4_flat[i*W +: W]) !== ex[i] || signed'(by4_flat[i*W +: W]) !== 0 ||
             signed'(ba4_flat[i*W +: W]) !== ea[i]) begin
            tests_failed++;
            $display("FAIL multi2_slot%0d: got (%0d,%0d,%0d) expected (%0d,0,%0d)", i,
                     signed'(bx4_flat[i*W +: W]), signed'(by4_flat[i*W +: W]),
                     signed'(ba4_flat[i*W +: W]), ex[i], ea[i]);
         end
      end
   endtask

   task automatic test_overrun();
      int lat, extra;
      tests_run++;
      if (overrun2 !== 1'b0) begin
         tests_failed++;
         $display("FAIL overrun_pre: got %b expected 0", overrun2);
      end
      frame2(18'sd8192, 18'sd0, 18'sd8192, 18'sd0, 18'sd16384, 20, lat);
      check2("overrun_frame", lat, 150, 8192, 0, 8192);
      tests_run++;
      if (overrun2 !== 1'b1) begin
         tests_failed++;
         $display("FAIL overrun_flag: got %b expected 1", overrun2);
      end
      extra = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (valid2 || busy2) extra++;
      end
      tests_run++;
      if (extra !== 0) begin
         tests_failed++;
         $display("FAIL overrun_ignored: got %0d busy/valid cycles expected 0", extra);
      end
      tests_run++;
      if (overrun2 !== 1'b1) begin
         tests_failed++;
         $display("FAIL overrun_sticky: got %b expected 1", overrun2);
      end
   endtask

   task automatic test_reset_midframe();
      int lat, seen;
      @(negedge clk);
      x2_flat = {18'sd0, 18'sd16384};
      y2_flat = {18'sd16384, 18'sd0};
      mix2_flat = 18'sd16384;
      en2 = 1'b1;
      clk_en2 = 1'b1;
      @(negedge clk);
      clk_en2 = 1'b0;
      repeat (50) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({bx2_flat, by2_flat, ba2_flat} !== '0) begin
         tests_failed++;
         $display("FAIL midreset_out: got %h expected 0", {bx2_flat, by2_flat, ba2_flat});
      end
      tests_run++;
      if ({valid2, busy2, overrun2} !== 3'b000) begin
         tests_failed++;
         $display("FAIL midreset_flags: got %b expected 000", {valid2, busy2, overrun2});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (valid2) seen++;
      end
      tests_run++;
      if (seen !== 0) begin
         tests_failed++;
         $display("FAIL midreset_no_commit: got %0d valid pulses expected 0", seen);
      end
      frame2(18'sd8192, 18'sd0, 18'sd8192, 18'sd0, 18'sd16384, 0, lat);
      check2("post_reset", lat, 150, 8192, 0, 8192);
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_quadrature();
      test_antiphase_zero();
      test_rounding();
      test_multi_channel();
      test_overrun();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/boundary_mixer_array.md
Name: boundary_mixer_array

Overview:
- Multi-channel, time-multiplexed successor to the single-pair boundary generator.
- Takes N_OSC attractor oscillators ordered by frequency and produces N_OSC-1 boundary oscillators, one per adjacent pair (k, k+1), at the geometric-mean frequency.
- Boundary amplitude is the geometric mean of the parent amplitudes, scaled by a per-pair mixing strength, along the averaged unit-vector phase direction.
- Uses one shared sequential square-root unit and one shared divider; results commit atomically with a valid pulse. Feeds SIE transition detection.

Parameters:
- WIDTH, 18, signed sample width.
- FRAC, 14, fractional bits (Q14).
- N_OSC, 4, number of input oscillators (>=2); boundaries NB = N_OSC-1.
- MIN_AMP, 164, amplitude floor used as divisor (0.01 in Q14).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  sample strobe; starts one frame when idle
- osc_x_flat  in  N_OSC*WIDTH  oscillator x; osc k at bits [k*WIDTH +: WIDTH]
- osc_y_flat  in  N_OSC*WIDTH  oscillator y, same packing
- mix_flat  in  NB*WIDTH  per-boundary mixing strength, Q14
- chan_en  in  NB  per-boundary enable mask
- boundary_x_flat  out  NB*WIDTH  boundary x, registered
- boundary_y_flat  out  NB*WIDTH  boundary y, registered
- boundary_amp_flat  out  NB*WIDTH  boundary amplitude, registered
- valid  out  1  one-cycle pulse on commit
- busy  out  1  high from capture to commit
- overrun  out  1  sticky: strobe arrived while busy

Behaviour:
- Reset (rst_n=0, async): all outputs 0, FSM to IDLE, shadow registers cleared. A reset mid-frame aborts the frame with no commit.
- Timing: the FSM advances every clk. clk_en is sampled only as a strobe.
- Capture: clk_en=1 in IDLE latches osc_x/y, mix and chan_en into snapshot registers, sets busy, sets k=0, goes to AMP.
- Overrun: clk_en=1 while busy is ignored and sets overrun. overrun clears only on reset.
- AMP (1 cycle):
  - If chan_en[k]=0: write zeros to the shadow slot k and go to NEXT.
  - Else: a = max(|x|,|y|) + ((min(|x|,|y|)*6554)>>>FRAC) for osc k and k+1; store P = a_lo*a_hi (2*WIDTH-bit unsigned).
- SQRT (WIDTH cycles): bit-serial restoring integer sqrt of P gives G = floor(sqrt(P)). Q28 in yields Q14 out.
- DIV (4*(WIDTH+FRAC) cycles): four sequential signed divisions: u_lo.x, u_lo.y, u_hi.x, u_hi.y.
  - Each u = (v<<<FRAC)/max(a, MIN_AMP), truncated toward zero, saturated to ±(2^(WIDTH-1)-1).
  - a=0 is therefore safe.
- MIX (1 cycle):
  - s = (u_lo + u_hi)>>>1, computed per axis in WIDTH+1 bits.
  - m = (G*mix_k)>>>FRAC.
  - bx = (m*s.x)>>>FRAC and by = (m*s.y)>>>FRAC, each saturated to WIDTH.
  - bamp = approx amplitude of (bx, by), saturated.
  - Write all three to shadow slot k.
- NEXT (0 extra cycles, merged into the slot write): if k=NB-1 go to COMMIT, else k+1 and go to AMP.
- COMMIT (1 cycle):
  - Copy all shadow slots to the outputs simultaneously.
  - Pulse valid for one cycle, clear busy, return to IDLE.
  - A new strobe is accepted the cycle after valid.
- Latency:
  - Enabled channel costs 2+WIDTH+4*(WIDTH+FRAC) cycles (148 at defaults). Disabled channel costs 1.
  - valid asserts 1 + sum(channel costs) + 1 cycles after the capture edge. Defaults with all enabled: 446.
- Outputs hold their last committed values between commits. Inputs may change freely after capture.
- Arithmetic: all multiplies are 2*WIDTH signed; >>> is arithmetic shift; negative products round toward −inf.

Test Plan:
- Aligned pair, N_OSC=2: osc0=(8192,0), osc1=(8192,0), mix=16384 -> G=8192, u=16384; boundary=(8192,0), amp=8192; valid at cycle 150 after strobe.
- Quadrature pair: osc0=(16384,0), osc1=(0,16384), mix=16384 -> boundary=(8192,8192), amp=11469.
- Anti-phase and zero-input: osc1=(-8192,0) against osc0=(8192,0) gives boundary (0,0), amp 0. osc=(0,0) on both gives outputs 0 with no divide fault (MIN_AMP path).
- Multi-channel, N_OSC=4, chan_en=3'b101, three aligned 0.5 pairs, mix=8192:
  - Slots 0 and 2 = (4096,0), amp 4096; slot 1 = 0.
  - valid at 1+148+1+148+1 = 299 cycles.
  - Outputs change only on the commit cycle.
- Overrun and reset: strobe during busy -> ignored, overrun=1, frame completes unchanged. Deassert rst_n mid-frame -> all outputs 0 immediately, no valid; next strobe runs a clean frame.
